// File: rtl/ysyx_25030093_sram_rd_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single SRAM AR/R read channel, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests; default is fixed LSU priority.
module ysyx_25030093_sram_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] sram_araddr,
  output logic              sram_arvalid,
  input  logic              sram_arready,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rvalid,
  output logic              sram_rready,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state, state_nxt;
  logic   lsu_pref;
  logic   lsu_win;
  logic   ifu_win;
  logic   r_done;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether the LSU owned the last completed read, so a tie goes to the other side.
  logic last_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu <= 1'b0;
    end else if (r_done) begin
      last_lsu <= gnt[1];
    end
  end

  assign lsu_pref = ~last_lsu;
`else
  assign lsu_pref = 1'b1;
`endif

  assign lsu_win = lsu_arvalid & (lsu_pref | ~ifu_arvalid);
  assign ifu_win = ifu_arvalid & ~lsu_win;

  always_comb begin
    state_nxt   = state;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    lsu_rdata   = '0;
    sram_rready = 1'b0;
    r_done      = 1'b0;
    case (state)
      IDLE: begin
        ifu_arready = ifu_win & ~rst;
        lsu_arready = lsu_win & ~rst;
        if (ifu_win | lsu_win) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (sram_arready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (gnt[0]) begin
          ifu_rvalid  = sram_rvalid;
          ifu_rdata   = sram_rdata;
          sram_rready = ifu_rready;
        end
        if (gnt[1]) begin
          lsu_rvalid  = sram_rvalid;
          lsu_rdata   = sram_rdata;
          sram_rready = lsu_rready;
        end
        r_done = sram_rvalid & sram_rready;
        if (r_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The accepted address is captured on the grant edge and held steady until SRAM takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= 2'b00;
      sram_arvalid <= 1'b0;
      sram_araddr  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (lsu_win) begin
            gnt          <= 2'b10;
            sram_araddr  <= lsu_araddr;
            sram_arvalid <= 1'b1;
          end else if (ifu_win) begin
            gnt          <= 2'b01;
            sram_araddr  <= ifu_araddr;
            sram_arvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (sram_arready) begin
            sram_arvalid <= 1'b0;
          end
        end
        DATA: begin
          if (r_done) begin
            gnt <= 2'b00;
          end
        end
        default: gnt <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_sram_rd_arbiter.sv
// Directed bench for the SRAM read arbiter; grants push expected owner/address/data into a scoreboard
// that is popped at the R handshake. Build with ARB_ROUND_ROBIN_EN to check the alternating tie-break.
module tb_ysyx_25030093_sram_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] sram_araddr;
  logic        sram_arvalid;
  logic        sram_arready;
  logic [31:0] sram_rdata;
  logic        sram_rvalid;
  logic        sram_rready;
  logic [1:0]  gnt;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ysyx_25030093_sram_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_arready (lsu_arready),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rready  (lsu_rready),
    .sram_araddr (sram_araddr),
    .sram_arvalid(sram_arvalid),
    .sram_arready(sram_arready),
    .sram_rdata  (sram_rdata),
    .sram_rvalid (sram_rvalid),
    .sram_rready (sram_rready),
    .gnt         (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la);
    ifu_arvalid = iv;
    ifu_araddr  = ia;
    lsu_arvalid = lv;
    lsu_araddr  = la;
    #1;
  endtask

  // Checks the accept handshake in IDLE, records what the winner should receive, then takes the edge.
  task automatic grant(input logic [1:0] owner, input logic [31:0] data);
    exp_t e;
    check_output("ifu_arready_idle", 32'(ifu_arready), 32'(owner[0]));
    check_output("lsu_arready_idle", 32'(lsu_arready), 32'(owner[1]));
    e.owner = owner;
    e.addr  = owner[1] ? lsu_araddr : ifu_araddr;
    e.data  = data;
    exp_q.push_back(e);
    tick();
  endtask

  // Plays the SRAM side of one read, starting in the cycle right after the grant edge.
  task automatic serve(input int ar_delay, input int rr_delay);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = exp_q[0];
    check_output("sram_arvalid_set", 32'(sram_arvalid), 32'd1);
    check_output("sram_araddr", sram_araddr, e.addr);
    check_output("gnt_addr", 32'(gnt), 32'(e.owner));
    repeat (ar_delay) begin
      tick();
      check_output("sram_arvalid_hold", 32'(sram_arvalid), 32'd1);
      check_output("sram_araddr_hold", sram_araddr, e.addr);
      check_output("arready_addr", 32'({ifu_arready, lsu_arready}), 32'd0);
    end
    sram_arready = 1'b1;
    sram_rvalid  = 1'b1;
    sram_rdata   = 32'hdead_beef;
    ifu_rready   = 1'b1;
    lsu_rready   = 1'b1;
    #1;
    check_output("sram_rready_addr", 32'(sram_rready), 32'd0);
    check_output("rvalid_addr", 32'({lsu_rvalid, ifu_rvalid}), 32'd0);
    tick();
    sram_arready = 1'b0;
    sram_rvalid  = 1'b0;
    ifu_rready   = 1'b0;
    lsu_rready   = 1'b0;
    sram_rdata   = e.data;
    #1;
    check_output("sram_arvalid_clr", 32'(sram_arvalid), 32'd0);
    check_output("gnt_data", 32'(gnt), 32'(e.owner));
    sram_rvalid = 1'b1;
    #1;
    repeat (rr_delay) begin
      check_output("sram_rready_hold", 32'(sram_rready), 32'd0);
      check_output("rvalid_hold", 32'({lsu_rvalid, ifu_rvalid}), 32'(e.owner));
      check_output("rdata_hold", e.owner[1] ? lsu_rdata : ifu_rdata, e.data);
      check_output("arready_hold", 32'({ifu_arready, lsu_arready}), 32'd0);
      tick();
    end
    ifu_rready = 1'b1;
    lsu_rready = 1'b1;
    #1;
    check_output("sram_rready_data", 32'(sram_rready), 32'd1);
    check_output("rvalid_data", 32'({lsu_rvalid, ifu_rvalid}), 32'(e.owner));
    check_output("rdata_owner", e.owner[1] ? lsu_rdata : ifu_rdata, e.data);
    check_output("rdata_other", e.owner[1] ? ifu_rdata : lsu_rdata, 32'd0);
    check_output("arready_rhs", 32'({ifu_arready, lsu_arready}), 32'd0);
    void'(exp_q.pop_front());
    tick();
    sram_rvalid = 1'b0;
    ifu_rready  = 1'b0;
    lsu_rready  = 1'b0;
    #1;
    check_output("gnt_idle", 32'(gnt), 32'd0);
  endtask

  logic [1:0] win;
  logic       last_lsu;

  initial begin
    rst          = 1'b1;
    ifu_araddr   = '0;
    ifu_arvalid  = 1'b0;
    ifu_rready   = 1'b0;
    lsu_araddr   = '0;
    lsu_arvalid  = 1'b0;
    lsu_rready   = 1'b0;
    sram_arready = 1'b0;
    sram_rdata   = '0;
    sram_rvalid  = 1'b0;
    #2;
    ifu_arvalid = 1'b1;
    #1;
    check_output("rst_gnt", 32'(gnt), 32'd0);
    check_output("rst_sram_arvalid", 32'(sram_arvalid), 32'd0);
    check_output("rst_sram_araddr", sram_araddr, 32'd0);
    check_output("rst_ifu_arready", 32'(ifu_arready), 32'd0);
    check_output("rst_sram_rready", 32'(sram_rready), 32'd0);
    ifu_arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] IFU-only read with slow AR and held rready");
    apply_stimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0);
    grant(2'b01, 32'h0000_0413);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    serve(2, 3);

    $display("[TB] simultaneous request, then waiting IFU, then LSU raised mid-IFU");
    apply_stimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000);
    grant(2'b10, 32'h1111_0001);
    apply_stimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0);
    serve(0, 0);
    grant(2'b01, 32'h0000_0093);
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h8000_2000);
    serve(1, 0);
    grant(2'b10, 32'h2222_0002);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    serve(0, 1);

    $display("[TB] reset during ADDR drops the transaction");
    apply_stimulus(1'b1, 32'h8000_0040, 1'b0, 32'h0);
    grant(2'b01, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("pre_rst_arvalid", 32'(sram_arvalid), 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_arvalid", 32'(sram_arvalid), 32'd0);
    check_output("mid_rst_gnt", 32'(gnt), 32'd0);
    check_output("mid_rst_araddr", sram_araddr, 32'd0);
    exp_q.delete();
    ifu_arvalid = 1'b1;
    #1;
    check_output("mid_rst_arready", 32'(ifu_arready), 32'd0);
    ifu_arvalid = 1'b0;
    rst = 1'b0;
    tick();
    sram_rvalid = 1'b1;
    sram_rdata  = 32'h5555_aaaa;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    #1;
    repeat (2) begin
      check_output("drop_rvalid", 32'({lsu_rvalid, ifu_rvalid}), 32'd0);
      check_output("drop_sram_rready", 32'(sram_rready), 32'd0);
      check_output("drop_gnt", 32'(gnt), 32'd0);
      tick();
    end
    sram_rvalid = 1'b0;
    ifu_rready  = 1'b0;
    lsu_rready  = 1'b0;

    $display("[TB] three consecutive simultaneous requests");
    last_lsu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h8000_0100 + 32'(i * 4), 1'b1, 32'h8000_3000 + 32'(i * 4));
`ifdef ARB_ROUND_ROBIN_EN
      win = last_lsu ? 2'b01 : 2'b10;
`else
      win = 2'b10;
`endif
      grant(win, 32'ha5a5_0000 + 32'(i));
      serve(0, 0);
      last_lsu = win[1];
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_sram_rd_arbiter.md
Name: ysyx_25030093_sram_rd_arbiter

Overview:
- Two-requester read arbiter sharing the single SRAM read channel (AR/R) between IFU (instruction fetch) and LSU (loads).
- Sits between both fetch/load units and the SRAM model. LSU write channels (AW/W/B) bypass this block.
- Serialises reads: one outstanding transaction at a time; grant is held from address accept until R handshake.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ifu_araddr  input  ADDR_W  IFU read address
ifu_arvalid  input  1  IFU address valid
ifu_arready  output  1  IFU address accepted
ifu_rdata  output  DATA_W  read data to IFU
ifu_rvalid  output  1  read data valid to IFU
ifu_rready  input  1  IFU ready for data
lsu_araddr  input  ADDR_W  LSU read address
lsu_arvalid  input  1  LSU address valid
lsu_arready  output  1  LSU address accepted
lsu_rdata  output  DATA_W  read data to LSU
lsu_rvalid  output  1  read data valid to LSU
lsu_rready  input  1  LSU ready for data
sram_araddr  output  ADDR_W  registered address to SRAM
sram_arvalid  output  1  registered address valid to SRAM
sram_arready  input  1  SRAM address ready
sram_rdata  input  DATA_W  SRAM read data
sram_rvalid  input  1  SRAM data valid
sram_rready  output  1  ready to SRAM
gnt  output  2  one-hot current owner: bit0 IFU, bit1 LSU, 00 idle

Behaviour:
- Reset (async, immediate): state IDLE, gnt=00, sram_arvalid=0, sram_araddr=0, last-owner pointer=IFU. All arready/rvalid/sram_rready outputs are 0 while rst=1.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE: if any arvalid, select winner.
  - Winner's arready=1 combinationally in that cycle; the handshake completes.
  - On the clock edge: latch the winner's araddr into sram_araddr, set sram_arvalid=1, set gnt, go to ADDR.
  - Loser's arready=0 and the loser must hold its request.
- Fixed priority (default): LSU beats IFU when both arvalid are high in the same cycle.
- ADDR: sram_arvalid held 1, sram_araddr stable. On sram_arready=1: clear sram_arvalid, go to DATA. Both arready=0.
- DATA:
  - Owner's rdata/rvalid driven combinationally from the sram signals; sram_rready = owner's rready.
  - Non-owner rvalid=0; its rdata is don't-care, driven 0.
  - On sram_rvalid & sram_rready: go to IDLE, gnt=00, last-owner pointer updated.
- Latency: request accepted cycle N; sram_arvalid high from N+1. Minimum turnaround to the next grant is one cycle after the R handshake (IDLE cycle).
- A new arvalid arriving in ADDR/DATA is not accepted until IDLE. No back-to-back grant in the same cycle as the R handshake.
- Simultaneous arvalid, sram_arready and sram_rvalid in ADDR: only the AR handshake is taken; sram_rready=0 in ADDR.
- rst asserted mid-transaction: immediate return to IDLE; any later SRAM response is dropped, since sram_rready=0 and rvalid is routed to nobody.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request the winner is the requester that was not the last owner; a single requester always wins.
- Undefined: fixed LSU priority; the last-owner pointer is unused and may be optimised away.

Test Plan:
- Only IFU requests araddr=0x8000_0000, sram_arready after 2 cycles, rdata=0x0000_0413 -> ifu_rvalid=1 with 0x0000_0413, lsu_rvalid stays 0, gnt 01 then 00.
- IFU and LSU both assert in the same cycle (LSU 0x8000_1000) -> lsu_arready=1, ifu_arready=0, sram_araddr=0x8000_1000. After LSU completes, IFU is granted next IDLE cycle.
- With ARB_ROUND_ROBIN_EN, three consecutive simultaneous requests (last owner IFU after reset) -> grant order LSU, IFU, LSU. Without the macro -> LSU, LSU, LSU.
- Owner holds rready=0 for 3 cycles while sram_rvalid=1 -> sram_rready=0, state stays DATA, rdata stable. Completes when rready rises.
- LSU arvalid raised during an IFU DATA phase -> lsu_arready=0 until the IDLE cycle after the IFU R handshake.
- rst pulsed in ADDR state -> sram_arvalid=0 and gnt=00 the same cycle. A following sram_rvalid produces no rvalid at either requester.
